cla_sub_15bit_pipe: RTL

- Pipelined carry-lookahead subtractor; inverse operation of the 15-bit CLA adder.
- Takes a 16-bit sum and one 15-bit addend, and recovers the other addend: diff = sum_in - input_2 - b_in.
- Two-stage pipeline with valid/ready handshake on both sides, so it can sit directly in the MFCC datapath behind adder outputs.
- Flags results that are negative or do not fit in 15 bits.

---
 rtl/cla_sub_15bit_pipe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cla_sub_15bit_pipe.sv
// Two-stage carry-lookahead subtractor: diff = sum_in - input_2 - b_in, split at bit 8.
// Optional underflow counter on err_cnt is enabled by defining CLA_SUB_ERRCNT_EN.
`timescale 1ns/1ps

module cla_sub_15bit_pipe #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH:0]   sum_in,
    input  logic [ADDR_WIDTH-1:0] input_2,
    input  logic                  b_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] diff,
    output logic                  underflow,
    output logic                  overflow,
    output logic [7:0]            err_cnt
);

    localparam int LO_W = 8;
    localparam int HI_W = ADDR_WIDTH + 1 - LO_W;

    // Flat 8-bit borrow lookahead: borrow[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]bin.
    function automatic logic [LO_W:0] borrows8(input logic [LO_W-1:0] g,
                                                input logic [LO_W-1:0] p,
                                                input logic            bin);
        logic [LO_W:0] bw;
        logic          acc;
        logic          pp;
        bw[0] = bin;
        for (int unsigned i = 0; i < LO_W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int unsigned j = i; j > 0; j--) begin
                acc = acc | (pp & g[j-1]);
                pp  = pp & p[j-1];
            end
            bw[i+1] = acc | (pp & bin);
        end
        return bw;
    endfunction

    logic                  s1_valid_q, s1_valid_d;
    logic [LO_W-1:0]       s1_dlo_q, s1_dlo_d;
    logic                  s1_borrow_q, s1_borrow_d;
    logic [HI_W-1:0]       s1_ahi_q, s1_ahi_d;
    logic [HI_W-2:0]       s1_bhi_q, s1_bhi_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [ADDR_WIDTH-1:0] diff_q, diff_d;
    logic                  underflow_q, underflow_d;
    logic                  overflow_q, overflow_d;

    logic            advance;
    logic [LO_W-1:0] a_lo, b_lo, a_hi, b_hi;
    logic [LO_W:0]   bw_lo, bw_hi;
    logic [LO_W-1:0] r_hi;

    assign advance  = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | advance;

    always_comb begin
        a_lo  = sum_in[LO_W-1:0];
        b_lo  = input_2[LO_W-1:0];
        bw_lo = borrows8(~a_lo & b_lo, ~(a_lo ^ b_lo), b_in);

        a_hi  = s1_ahi_q;
        b_hi  = {1'b0, s1_bhi_q};
        bw_hi = borrows8(~a_hi & b_hi, ~(a_hi ^ b_hi), s1_borrow_q);
        r_hi  = a_hi ^ b_hi ^ bw_hi[LO_W-1:0];

        s1_valid_d  = s1_valid_q;
        s1_dlo_d    = s1_dlo_q;
        s1_borrow_d = s1_borrow_q;
        s1_ahi_d    = s1_ahi_q;
        s1_bhi_d    = s1_bhi_q;
        s2_valid_d  = s2_valid_q;
        diff_d      = diff_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_dlo_d    = a_lo ^ b_lo ^ bw_lo[LO_W-1:0];
                s1_borrow_d = bw_lo[LO_W];
                s1_ahi_d    = sum_in[ADDR_WIDTH:LO_W];
                s1_bhi_d    = input_2[ADDR_WIDTH-1:LO_W];
            end
        end

        // Result registers only change on a real load, so a stalled output stays put.
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d      = {r_hi[LO_W-2:0], s1_dlo_q};
                underflow_d = bw_hi[LO_W];
                overflow_d  = ~bw_hi[LO_W] & r_hi[LO_W-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_dlo_q    <= '0;
            s1_borrow_q <= 1'b0;
            s1_ahi_q    <= '0;
            s1_bhi_q    <= '0;
            s2_valid_q  <= 1'b0;
            diff_q      <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_dlo_q    <= s1_dlo_d;
            s1_borrow_q <= s1_borrow_d;
            s1_ahi_q    <= s1_ahi_d;
            s1_bhi_q    <= s1_bhi_d;
            s2_valid_q  <= s2_valid_d;
            diff_q      <= diff_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

`ifdef CLA_SUB_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s2_valid_q && out_ready && underflow_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
